// File: rtl/neopixel_rx_pkg.sv
// Shared constants for the WS2812-style one-wire receiver: default 50 MHz
// timing, FSM state codes and error flag bit positions.
package neopixel_rx_pkg;

  localparam int DEF_MIN_HIGH   = 5;
  localparam int DEF_BIT_THRESH = 30;
  localparam int DEF_MAX_HIGH   = 60;
  localparam int DEF_LATCH_LOW  = 2500;

  localparam logic [1:0] ST_WAIT_LATCH = 2'd0;
  localparam logic [1:0] ST_IDLE       = 2'd1;
  localparam logic [1:0] ST_HIGH       = 2'd2;
  localparam logic [1:0] ST_LOW        = 2'd3;

  localparam int ERR_GLITCH   = 0;
  localparam int ERR_TOO_LONG = 1;
  localparam int ERR_OVERFLOW = 2;
  localparam int ERR_PARTIAL  = 3;

endpackage

// File: rtl/neopixel_rx_sync.sv
// Two-flop synchronizer for the asynchronous one-wire line, plus a delayed
// copy that yields single-cycle rise/fall pulses on the synchronized level.
module one_wire_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic line_async,
  output logic line_sync,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = line_async;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_sync = sync_q;
  assign rise      = sync_q & ~prev_q;
  assign fall      = ~sync_q & prev_q;

endmodule

// File: rtl/neopixel_rx.sv
// WS2812-style one-wire decoder: classifies high pulses by width, assembles
// MSB-first 24-bit GRB pixels, and hands them out over valid/ready.
module neopixel_rx
  import neopixel_rx_pkg::*;
#(
  parameter int MIN_HIGH   = DEF_MIN_HIGH,
  parameter int BIT_THRESH = DEF_BIT_THRESH,
  parameter int MAX_HIGH   = DEF_MAX_HIGH,
  parameter int LATCH_LOW  = DEF_LATCH_LOW
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        one_wire,
  input  logic        enable,
  output logic [23:0] pixel_data,
  output logic [7:0]  pixel_index,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_end,
  output logic [8:0]  frame_pixels,
  output logic [3:0]  error_flags,
  input  logic        clear_errors
);

  localparam int LW = $clog2(LATCH_LOW + 1);
  localparam int HW = $clog2(MAX_HIGH + 2);

  localparam logic [LW-1:0] LOW_LAST = LW'(LATCH_LOW - 1);
  localparam logic [HW-1:0] MIN_W    = HW'(MIN_HIGH);
  localparam logic [HW-1:0] THRESH_W = HW'(BIT_THRESH);
  localparam logic [HW-1:0] MAX_W    = HW'(MAX_HIGH);

  logic line_sync, rise, fall;

  one_wire_sync u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_async (one_wire),
    .line_sync  (line_sync),
    .rise       (rise),
    .fall       (fall)
  );

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic [HW-1:0] high_cnt_q, high_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [22:0]   shift_q, shift_d;
  logic [8:0]    pix_cnt_q, pix_cnt_d;
  logic [23:0]   pixel_data_q, pixel_data_d;
  logic [7:0]    pixel_index_q, pixel_index_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic          frame_end_q, frame_end_d;
  logic [8:0]    frame_pixels_q, frame_pixels_d;
  logic [3:0]    err_q, err_d;

  logic       bit_done, bit_val, pix_done, accept;
  logic [3:0] err_set;

  always_comb begin
    state_d        = state_q;
    low_cnt_d      = low_cnt_q;
    high_cnt_d     = high_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    pix_cnt_d      = pix_cnt_q;
    pixel_data_d   = pixel_data_q;
    pixel_index_d  = pixel_index_q;
    frame_end_d    = 1'b0;
    frame_pixels_d = frame_pixels_q;
    err_set        = 4'b0;
    bit_done       = 1'b0;
    bit_val        = 1'b0;
    pix_done       = 1'b0;

    // Disabling abandons the frame quietly; a fresh latch gap is required.
    if (!enable) begin
      state_d   = ST_WAIT_LATCH;
      low_cnt_d = '0;
      bit_cnt_d = '0;
      pix_cnt_d = '0;
    end else begin
      case (state_q)
        ST_WAIT_LATCH: begin
          bit_cnt_d = '0;
          pix_cnt_d = '0;
          if (line_sync) begin
            low_cnt_d = '0;
          end else if (low_cnt_q == LOW_LAST) begin
            low_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            low_cnt_d = low_cnt_q + LW'(1);
          end
        end
        ST_IDLE: begin
          if (rise) begin
            state_d    = ST_HIGH;
            high_cnt_d = HW'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            if (high_cnt_q < MIN_W) begin
              err_set[ERR_GLITCH] = 1'b1;
              state_d             = ST_WAIT_LATCH;
              low_cnt_d           = '0;
            end else begin
              bit_done  = 1'b1;
              bit_val   = (high_cnt_q >= THRESH_W);
              state_d   = ST_LOW;
              low_cnt_d = LW'(1);
            end
          end else if (high_cnt_q >= MAX_W) begin
            err_set[ERR_TOO_LONG] = 1'b1;
            state_d               = ST_WAIT_LATCH;
            low_cnt_d             = '0;
          end else begin
            high_cnt_d = high_cnt_q + HW'(1);
          end
        end
        default: begin
          if (rise) begin
            state_d    = ST_HIGH;
            high_cnt_d = HW'(1);
          end else if (low_cnt_q == LOW_LAST) begin
            frame_end_d    = 1'b1;
            frame_pixels_d = pix_cnt_q;
            if (bit_cnt_q != 5'd0) err_set[ERR_PARTIAL] = 1'b1;
            bit_cnt_d = '0;
            pix_cnt_d = '0;
            low_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            low_cnt_d = low_cnt_q + LW'(1);
          end
        end
      endcase
    end

    if (bit_done) begin
      shift_d = {shift_q[21:0], bit_val};
      if (bit_cnt_q == 5'd23) begin
        pix_done  = 1'b1;
        bit_cnt_d = '0;
        pix_cnt_d = (pix_cnt_q == 9'h1FF) ? pix_cnt_q : pix_cnt_q + 9'd1;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end

    // A finished pixel only replaces the output slot if it is free this cycle.
    accept        = pixel_valid_q & pixel_ready;
    pixel_valid_d = pixel_valid_q & ~accept;
    if (pix_done) begin
      if (!pixel_valid_q || accept) begin
        pixel_data_d  = {shift_q, bit_val};
        pixel_index_d = (pix_cnt_q > 9'd255) ? 8'hFF : pix_cnt_q[7:0];
        pixel_valid_d = 1'b1;
      end else begin
        err_set[ERR_OVERFLOW] = 1'b1;
      end
    end

    err_d = (clear_errors ? 4'b0 : err_q) | err_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_WAIT_LATCH;
      low_cnt_q      <= '0;
      high_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      pix_cnt_q      <= '0;
      pixel_data_q   <= '0;
      pixel_index_q  <= '0;
      pixel_valid_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_pixels_q <= '0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      low_cnt_q      <= low_cnt_d;
      high_cnt_q     <= high_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      pix_cnt_q      <= pix_cnt_d;
      pixel_data_q   <= pixel_data_d;
      pixel_index_q  <= pixel_index_d;
      pixel_valid_q  <= pixel_valid_d;
      frame_end_q    <= frame_end_d;
      frame_pixels_q <= frame_pixels_d;
      err_q          <= err_d;
    end
  end

  assign pixel_data   = pixel_data_q;
  assign pixel_index  = pixel_index_q;
  assign pixel_valid  = pixel_valid_q;
  assign frame_end    = frame_end_q;
  assign frame_pixels = frame_pixels_q;
  assign error_flags  = err_q;

endmodule
